// File: rtl/wb_select_stage_if.sv
// Bundle of upstream result, writeback and control signals for wb_select_stage.
// The master side is the producer and register file; the slave side is the stage.
interface wb_select_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NSRC*WIDTH-1:0] src;
    logic [SELW-1:0]       sel;
    logic                  regwrite;
    logic [4:0]            rd;
    logic [1:0]            ldsize;
    logic                  ldsigned;
    logic [1:0]            byteoff;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      wb_data;
    logic [4:0]            wb_rd;
    logic                  wb_we;
    logic [31:0]           retired;

    modport master (
        output in_valid, src, sel, regwrite, rd, ldsize, ldsigned, byteoff, flush, out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_we, retired
    );

    modport slave (
        input  in_valid, src, sel, regwrite, rd, ldsize, ldsigned, byteoff, flush, out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_we, retired
    );
endinterface

// File: rtl/wb_select_stage.sv
// Writeback select stage: picks one of NSRC sources, buffers results in a 2-entry FIFO.
// Define WB_SELECT_STAGE_LOADEXT_EN to extract and extend sub-word loads on source 1.
module wb_select_stage #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_select_stage_if.slave  bus
);
    logic [WIDTH-1:0] w_mem;
    logic [WIDTH-1:0] w_sdata;
    logic             w_we;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_countNext;

    logic [1:0]       r_count;
    logic             r_wptr;
    logic             r_rptr;
    logic             r_inReady;
    logic [31:0]      r_retired;
    logic [WIDTH-1:0] r_data [2];
    logic [4:0]       r_rd   [2];
    logic             r_we   [2];

`ifdef WB_SELECT_STAGE_LOADEXT_EN
    logic [WIDTH-1:0] w_src1;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    assign w_src1 = bus.src[WIDTH +: WIDTH];
    assign w_byte = w_src1[{bus.byteoff, 3'b000} +: 8];
    assign w_half = w_src1[{bus.byteoff[1], 4'b0000} +: 16];

    always_comb begin
        case (bus.ldsize)
            2'b00:   w_mem = {{(WIDTH-8){bus.ldsigned & w_byte[7]}}, w_byte};
            2'b01:   w_mem = {{(WIDTH-16){bus.ldsigned & w_half[15]}}, w_half};
            default: w_mem = w_src1;
        endcase
    end
`else
    logic w_unused;

    assign w_mem    = bus.src[WIDTH +: WIDTH];
    assign w_unused = ^{bus.ldsize, bus.ldsigned, bus.byteoff};
`endif

    // Out-of-range selects fall through to zero because no iteration matches.
    always_comb begin
        w_sdata = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.sel == SELW'(k)) begin
                w_sdata = (k == 1) ? w_mem : bus.src[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_we   = bus.regwrite && (bus.rd != 5'd0);
    assign w_push = bus.in_valid && r_inReady;
    assign w_pop  = (r_count != 2'd0) && bus.out_ready;

    always_comb begin
        w_countNext = r_count;
        if (bus.flush) begin
            w_countNext = 2'd0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - 2'd1;
        end
    end

    // in_ready is registered from the next count so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_inReady <= 1'b1;
            r_retired <= 32'd0;
        end else begin
            r_count   <= w_countNext;
            r_inReady <= (w_countNext != 2'd2);
            if (bus.flush) begin
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                    if (r_we[r_rptr]) begin
                        r_retired <= r_retired + 32'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) begin
            r_data[r_wptr] <= w_sdata;
            r_rd[r_wptr]   <= bus.rd;
            r_we[r_wptr]   <= w_we;
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.wb_data   = bus.out_valid ? r_data[r_rptr] : '0;
    assign bus.wb_rd     = bus.out_valid ? r_rd[r_rptr] : 5'd0;
    assign bus.wb_we     = bus.out_valid && r_we[r_rptr];
    assign bus.retired   = r_retired;
endmodule
